plot_sink: RTL and testbench
============================

// Module: plot_sink
// PURPOSE
// - Receiving end of the plot stream (x, y, colour, plot strobe) emitted by the square/sprite drawers.
// - Clips each pixel to the 160x120 screen, computes the linear framebuffer address and buffers writes in a small FIFO.
// - Drains the FIFO into a single-port framebuffer write port that can stall; sits between the drawers and the VGA framebuffer RAM.
// PARAMETERS
// - SCREEN_W    160  visible width in pixels; x >= SCREEN_W is clipped
// - SCREEN_H    120  visible height in pixels; y >= SCREEN_H is clipped
// - FIFO_DEPTH  8    write-buffer entries; power of two, >= 2
// PORTS
// - clk        in   1   system clock (CLOCK_50)
// - reset      in   1   synchronous, active-high reset
// - plot       in   1   pixel-valid strobe, one pixel per cycle while high
// - x          in   8   pixel column
// - y          in   7   pixel row
// - colour     in   3   pixel colour {R,G,B}
// - mem_addr   out  15  framebuffer address = y*SCREEN_W + x
// - mem_data   out  3   framebuffer write colour
// - mem_we     out  1   write enable; write occurs on a cycle with mem_we && mem_ready
// - mem_ready  in   1   framebuffer accepts a write this cycle
// - full       out  1   FIFO holds FIFO_DEPTH entries
// - overflow   out  1   sticky: an in-range pixel was dropped because FIFO full
// - clip_count out  8   saturating count of clipped pixels
// BEHAVIOUR
// - Reset: every output 0 (mem_addr, mem_data, mem_we, full, overflow, clip_count); FIFO emptied; input stage invalid.
// - Stage 1 (input register): on plot=1, register {addr, colour, valid}; addr = (y<<7)+(y<<5)+x in 15 bits (max 19199, no overflow).
// - Clip check on raw x/y in stage 1: x >= SCREEN_W or y >= SCREEN_H -> valid=0, clip_count += 1, saturating at 255.
// - Stage 2 (FIFO push): valid stage-1 entry pushed next cycle. No backpressure to drawers (they cannot stall).
// - Push when full and no pop that cycle: entry dropped, overflow <= 1 (held until reset).
// - Simultaneous push and pop when full: both succeed, count unchanged, no drop, overflow unchanged.
// - Simultaneous push and pop when empty: push succeeds; pop is not possible (mem_we low), count becomes 1.
// - Output: mem_we = FIFO not empty; mem_addr/mem_data = FIFO head (first-word fall-through, combinational from head).
// - Pop when mem_we && mem_ready; mem_ready low holds head stable, mem_we stays high.
// - Latency: plot at cycle N with empty FIFO and mem_ready=1 -> mem_we=1 with that pixel during cycle N+2.
// - Ordering: writes leave in arrival order; no coalescing of repeated addresses.
// - full = (count == FIFO_DEPTH); count width clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
// - Reset asserted mid-stream: next cycle mem_we=0, FIFO and stage 1 discarded, pending pixels lost.
// - Throughput: sustained 1 pixel/cycle while mem_ready stays high; a 16-pixel 4x4 burst needs no buffering.
// STRUCTURE
// - Package draw_pkg: SCREEN_W/SCREEN_H defaults, X_W=8, Y_W=7, COLOUR_W=3, ADDR_W=15, typedef plot_entry_t {addr, colour}.
// - Sub-module plot_fifo: synchronous FIFO of plot_entry_t, parameter DEPTH, ports push/pop/din/dout/empty/full;
//   push-when-full ignored internally, overflow detection lives in plot_sink.
// - plot_sink top: stage-1 register, clip logic, clip counter, overflow flag, plot_fifo instance, mem port wiring.
// TESTING
// - Single pixel: plot=1 x=3 y=2 col=5, mem_ready=1 -> two cycles later mem_we=1 addr=323 data=5 for exactly 1 cycle.
// - 4x4 burst at (10,20), mem_ready=1 -> 16 writes addr 3210..3213, 3370..3373, 3530..3533, 3690..3693 in order; overflow=0.
// - Clipping: pixels (160,0), (0,120), (255,127) -> no mem_we, clip_count=3; (159,119) -> addr 19199 written.
// - Stall: mem_ready=0 during 10-pixel burst, DEPTH=8 -> full=1, overflow=1, first 8 pixels later drain in order, pixels 9-10 lost.
// - Full with simultaneous pop: hold full, release mem_ready one cycle while plotting -> one write, one push, overflow stays 0.
// - Reset mid-burst: reset high 1 cycle after 5 buffered pixels -> next cycle mem_we=0, full=0, clip_count=0, no stale writes after.

Source files
------------

// File: rtl/draw_pkg.sv
// Shared types and constants for the plot stream feeding the 160x120 framebuffer.
package draw_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 3;
  localparam int ADDR_W   = 15;

  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic [COLOUR_W-1:0] colour;
  } plot_entry_t;

  // y*160 + x via shifts; the largest on-screen result (19199) fits in 15 bits
  function automatic logic [ADDR_W-1:0] calc_addr(input logic [Y_W-1:0] y, input logic [X_W-1:0] x);
    logic [ADDR_W-1:0] y_ext;
    y_ext = {8'd0, y};
    return (y_ext << 7) + (y_ext << 5) + {7'd0, x};
  endfunction
endpackage

// File: rtl/plot_fifo.sv
// First-word fall-through FIFO of plot entries; a push while full (and not popping) is ignored.
module plot_fifo
  import draw_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  plot_entry_t din,
  output plot_entry_t dout,
  output logic        empty,
  output logic        full
);
  localparam int PTR_W = $clog2(DEPTH);

  plot_entry_t        mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [PTR_W:0]     count_r;
  logic               push_ok_s;
  logic               pop_ok_s;

  // Accept a push when full only if the head leaves in the same cycle
  always_comb begin
    empty     = (count_r == '0);
    full      = (count_r == (PTR_W+1)'(DEPTH));
    pop_ok_s  = pop && !empty;
    push_ok_s = push && (!full || pop_ok_s);
    dout      = mem_r[rd_ptr_r];
  end

  // Entry storage
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= din;
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end
endmodule

// File: rtl/plot_sink.sv
// Clips incoming plot pixels, converts them to framebuffer addresses and buffers
// them ahead of a stallable framebuffer write port.
module plot_sink
  import draw_pkg::*;
#(
  parameter int SCREEN_W   = draw_pkg::SCREEN_W,
  parameter int SCREEN_H   = draw_pkg::SCREEN_H,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                plot,
  input  logic [X_W-1:0]      x,
  input  logic [Y_W-1:0]      y,
  input  logic [COLOUR_W-1:0] colour,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [COLOUR_W-1:0] mem_data,
  output logic                mem_we,
  input  logic                mem_ready,
  output logic                full,
  output logic                overflow,
  output logic [7:0]          clip_count
);
  localparam logic [X_W:0] X_LIM = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] Y_LIM = (Y_W+1)'(SCREEN_H);

  logic        s1_valid_r;
  plot_entry_t s1_entry_r;
  logic [7:0]  clip_count_r;
  logic        overflow_r;
  logic        clip_s;
  logic        pop_s;
  logic        fifo_empty_s;
  logic        fifo_full_s;
  plot_entry_t head_s;

  assign clip_s = ({1'b0, x} >= X_LIM) || ({1'b0, y} >= Y_LIM);
  assign pop_s  = !fifo_empty_s && mem_ready;

  // Stage 1: register the pixel, invalidating it when off-screen
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      s1_entry_r <= '0;
    end else begin
      s1_valid_r <= plot && !clip_s;
      if (plot) s1_entry_r <= '{addr: calc_addr(y, x), colour: colour};
    end
  end

  // Saturating clip counter and sticky overflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      clip_count_r <= 8'd0;
      overflow_r   <= 1'b0;
    end else begin
      if (plot && clip_s && (clip_count_r != 8'hFF)) clip_count_r <= clip_count_r + 8'd1;
      if (s1_valid_r && fifo_full_s && !pop_s) overflow_r <= 1'b1;
    end
  end

  plot_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (s1_valid_r),
    .pop   (pop_s),
    .din   (s1_entry_r),
    .dout  (head_s),
    .empty (fifo_empty_s),
    .full  (fifo_full_s)
  );

  // Stale RAM contents never reach the port while the buffer is empty
  assign mem_we     = !fifo_empty_s;
  assign mem_addr   = fifo_empty_s ? '0 : head_s.addr;
  assign mem_data   = fifo_empty_s ? '0 : head_s.colour;
  assign full       = fifo_full_s;
  assign overflow   = overflow_r;
  assign clip_count = clip_count_r;
endmodule

// File: tb/tb_plot_sink.sv
// Directed and random stimulus for plot_sink, checked against a queue-based model.
module tb_plot_sink;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        plot = 1'b0;
  logic [7:0]  x = 8'd0;
  logic [6:0]  y = 7'd0;
  logic [2:0]  colour = 3'd0;
  logic [14:0] mem_addr;
  logic [2:0]  mem_data;
  logic        mem_we;
  logic        mem_ready = 1'b1;
  logic        full;
  logic        overflow;
  logic [7:0]  clip_count;

  plot_sink dut (
    .clk(clk), .reset(reset), .plot(plot), .x(x), .y(y), .colour(colour),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_ready(mem_ready),
    .full(full), .overflow(overflow), .clip_count(clip_count)
  );

  always #5 clk = ~clk;

  localparam int DEPTH = 8;

  int tests = 0;
  int fails = 0;

  // Model: pending pixel, buffered writes, flags, and a log of written pixels
  int q_addr[$];
  int q_col[$];
  int wlog[$];
  bit m_s1_v = 1'b0;
  int m_s1_addr = 0;
  int m_s1_col = 0;
  int m_clip = 0;
  bit m_ovf = 1'b0;
  bit chk_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    chk("mem_we", {31'd0, mem_we}, (q_addr.size() > 0) ? 32'd1 : 32'd0);
    if (q_addr.size() > 0) begin
      chk("mem_addr", {17'd0, mem_addr}, q_addr[0]);
      chk("mem_data", {29'd0, mem_data}, q_col[0]);
    end
    chk("full", {31'd0, full}, (q_addr.size() == DEPTH) ? 32'd1 : 32'd0);
    chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    chk("clip_count", {24'd0, clip_count}, m_clip);
  endtask

  task automatic step(input bit rst, input bit p, input int px, input int py, input int pc, input bit rdy);
    bit in_range;
    reset = rst; plot = p; x = px[7:0]; y = py[6:0]; colour = pc[2:0]; mem_ready = rdy;
    if (chk_en) check_outputs();
    if (rst) begin
      q_addr.delete(); q_col.delete();
      m_s1_v = 1'b0; m_clip = 0; m_ovf = 1'b0; chk_en = 1'b1;
    end else begin
      if (q_addr.size() > 0 && rdy) begin
        wlog.push_back(q_addr[0]);
        void'(q_addr.pop_front()); void'(q_col.pop_front());
      end
      if (m_s1_v) begin
        if (q_addr.size() < DEPTH) begin
          q_addr.push_back(m_s1_addr); q_col.push_back(m_s1_col);
        end else m_ovf = 1'b1;
      end
      in_range = (px < 160) && (py < 120);
      m_s1_v = p && in_range;
      m_s1_addr = py * 160 + px;
      m_s1_col = pc;
      if (p && !in_range && m_clip < 255) m_clip++;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 0, rdy);
  endtask

  initial begin
    // Reset state
    step(1'b1, 1'b0, 0, 0, 0, 1'b1);
    step(1'b1, 1'b0, 0, 0, 0, 1'b1);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_addr", {17'd0, mem_addr}, 32'd0);
    chk("rst_data", {29'd0, mem_data}, 32'd0);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_clip", {24'd0, clip_count}, 32'd0);

    // Single pixel: visible two cycles after plot, for one cycle
    step(1'b0, 1'b1, 3, 2, 5, 1'b1);
    step(1'b0, 1'b0, 0, 0, 0, 1'b1);
    chk("single_we", {31'd0, mem_we}, 32'd1);
    chk("single_addr", {17'd0, mem_addr}, 32'd323);
    chk("single_data", {29'd0, mem_data}, 32'd5);
    step(1'b0, 1'b0, 0, 0, 0, 1'b1);
    chk("single_once", {31'd0, mem_we}, 32'd0);

    // 4x4 burst at (10,20)
    wlog.delete();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) step(1'b0, 1'b1, 10 + c, 20 + r, (r + c) % 8, 1'b1);
    idle(4, 1'b1);
    chk("burst_n", wlog.size(), 32'd16);
    for (int i = 0; i < 16 && i < wlog.size(); i++)
      chk("burst_addr", wlog[i], 3210 + (i / 4) * 160 + (i % 4));
    chk("burst_ovf", {31'd0, overflow}, 32'd0);

    // Clipping
    wlog.delete();
    step(1'b0, 1'b1, 160, 0, 1, 1'b1);
    step(1'b0, 1'b1, 0, 120, 2, 1'b1);
    step(1'b0, 1'b1, 255, 127, 3, 1'b1);
    step(1'b0, 1'b1, 159, 119, 7, 1'b1);
    idle(3, 1'b1);
    chk("clip_cnt", {24'd0, clip_count}, 32'd3);
    chk("clip_n", wlog.size(), 32'd1);
    if (wlog.size() > 0) chk("clip_corner", wlog[0], 32'd19199);

    // Stall during a 10-pixel burst
    wlog.delete();
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, i, 5, i % 8, 1'b0);
    idle(1, 1'b0);
    chk("stall_full", {31'd0, full}, 32'd1);
    chk("stall_ovf", {31'd0, overflow}, 32'd1);
    idle(10, 1'b1);
    chk("stall_n", wlog.size(), 32'd8);
    for (int i = 0; i < 8 && i < wlog.size(); i++) chk("stall_addr", wlog[i], 800 + i);

    // Full with simultaneous push and pop
    step(1'b1, 1'b0, 0, 0, 0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, i, 9, 1, 1'b0);
    step(1'b0, 1'b1, 50, 50, 6, 1'b0);
    step(1'b0, 1'b0, 0, 0, 0, 1'b1);
    idle(2, 1'b0);
    chk("fullpp_full", {31'd0, full}, 32'd1);
    chk("fullpp_ovf", {31'd0, overflow}, 32'd0);
    idle(10, 1'b1);

    // Reset mid-burst
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 20 + i, 30, 2, 1'b0);
    step(1'b0, 1'b1, 200, 0, 0, 1'b0);
    step(1'b1, 1'b1, 40, 40, 4, 1'b1);
    chk("rstmid_we", {31'd0, mem_we}, 32'd0);
    chk("rstmid_full", {31'd0, full}, 32'd0);
    chk("rstmid_clip", {24'd0, clip_count}, 32'd0);
    wlog.delete();
    idle(4, 1'b1);
    chk("rstmid_stale", wlog.size(), 32'd0);

    // Clip counter saturation
    for (int i = 0; i < 260; i++) step(1'b0, 1'b1, 160 + (i % 96), i % 128, 0, 1'b1);
    idle(1, 1'b1);
    chk("clip_sat", {24'd0, clip_count}, 32'd255);

    // Random traffic
    step(1'b1, 1'b0, 0, 0, 0, 1'b1);
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 149) == 0), ($urandom_range(0, 9) < 7),
           $urandom_range(0, 200), $urandom_range(0, 127), $urandom_range(0, 7),
           ($urandom_range(0, 1) == 1));
    end
    idle(12, 1'b1);
    check_outputs();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
